// File: rtl/iob_native_arb_pkg.sv
// Shared types and constants for the IOb native round-robin arbiter.
// Holds the FSM state encoding, the timeout read value and width helpers.
package iob_native_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Read data returned to a master whose access was killed by the watchdog.
    localparam int unsigned ARB_TO_RDATA = 0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/iob_rr_pick.sv
// Combinational rotating-priority picker: first requester at or after rr_ptr,
// wrapping around, reported both one-hot and as an index.
module iob_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx
);

    always_comb begin
        int   pos;
        logic found;
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        pos      = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(rr_ptr) + k) % N;
            if (!found && req[pos]) begin
                pick[pos] = 1'b1;
                pick_idx  = IDX_W'(pos);
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_native_arb.sv
// Round-robin arbiter sharing one IOb native slave among N_MASTERS masters,
// with registered request forwarding and a per-transaction watchdog.
module iob_native_arb
    import iob_native_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_MASTERS-1:0]        m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [DATA_W-1:0]           m_rdata,
    output logic [N_MASTERS-1:0]        m_ready,
    output logic                        s_valid,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [DATA_W/8-1:0]         s_wstrb,
    input  logic [DATA_W-1:0]           s_rdata,
    input  logic                        s_ready,
    output logic [N_MASTERS-1:0]        grant,
    output logic                        err
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(N_MASTERS);
    localparam int CNT_W  = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wd_cnt;
    logic [N_MASTERS-1:0] pick;
    logic [IDX_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [STRB_W-1:0] sel_wstrb;
    logic              to_hit;
    logic              done_ok;
    logic              done_to;

    iob_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req      (m_valid),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // Fields of the picked master; pick is one-hot so a plain OR-mux suffices.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (pick[i]) begin
                sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = m_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = m_wstrb[i*STRB_W +: STRB_W];
            end
        end
    end

    assign to_hit = (TIMEOUT > 0) && (wd_cnt == TO_LAST);

    always_comb begin
        state_nxt = state;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|m_valid) state_nxt = ARB_BUSY;
            end
            ARB_BUSY: begin
                // A slave ready in the timeout cycle takes precedence over the watchdog.
                if (s_ready) begin
                    done_ok   = 1'b1;
                    state_nxt = ARB_IDLE;
                end else if (to_hit) begin
                    done_to   = 1'b1;
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign s_valid = (state == ARB_BUSY);
    assign m_ready = (done_ok || done_to) ? grant : '0;
    assign m_rdata = done_ok ? s_rdata : DATA_W'(ARB_TO_RDATA);
    assign err     = done_to;

    always_ff @(posedge clk) begin
        // NOTE: the latched request fields are reset too, so s_* read 0 out of reset.
        if (!rst_n) begin
            state   <= ARB_IDLE;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            grant   <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments only.
            state <= state_nxt;
            case (state)
                ARB_IDLE: begin
                    if (|m_valid) begin
                        s_addr  <= sel_addr;
                        s_wdata <= sel_wdata;
                        s_wstrb <= sel_wstrb;
                        grant   <= pick;
                        rr_ptr  <= (pick_idx == IDX_W'(N_MASTERS - 1)) ? '0 : pick_idx + 1'b1;
                        wd_cnt  <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (done_ok || done_to) begin
                        grant <= '0;
                    end else if (TIMEOUT > 0) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: grant <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_native_arb.sv
// Self-checking bench for iob_native_arb: directed stimulus with a scoreboard
// of expected completions compared whenever the arbiter pulses m_ready.
module tb_iob_native_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    m_valid;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    logic [DW-1:0]   m_rdata;
    logic [N-1:0]    m_ready;
    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic [DW-1:0]   s_rdata;
    logic            s_ready;
    logic [N-1:0]    grant;
    logic            err;

    typedef struct {
        int          idx;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   sv_cnt;

    iob_native_arb #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_wstrb (s_wstrb),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .grant   (grant),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
        m_addr[i*AW +: AW]  = a;
        m_wdata[i*DW +: DW] = d;
        m_wstrb[i*SW +: SW] = s;
    endtask

    task automatic expect_done(input int idx, input logic [31:0] rd, input logic e);
        exp_t x;
        x.idx   = idx;
        x.rdata = rd;
        x.err   = e;
        sb.push_back(x);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_s_valid"}, 64'(s_valid), 64'd0);
        check({tag, "_grant"},   64'(grant),   64'd0);
        check({tag, "_m_ready"}, 64'(m_ready), 64'd0);
        check({tag, "_err"},     64'(err),     64'd0);
        check({tag, "_s_addr"},  64'(s_addr),  64'd0);
        check({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
        check({tag, "_s_wstrb"}, 64'(s_wstrb), 64'd0);
        check({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
    endtask

    // Scoreboard consumer: every completion pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (m_ready != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", 64'(m_ready), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_owner", 64'(m_ready), 64'(1) << mon_e.idx);
                check("ready_rdata", 64'(m_rdata), 64'(mon_e.rdata));
                check("ready_err",   64'(err),     64'(mon_e.err));
            end
        end else if (err) begin
            check("err_without_ready", 64'(err), 64'd0);
        end
    end

    initial begin
        rst_n   = 1'b0;
        m_valid = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        s_rdata = '0;
        s_ready = 1'b0;

        // Reset state
        next_cycle();
        next_cycle();
        settle();
        check_idle_outputs("reset");
        next_cycle();
        rst_n = 1'b1;

        // Single read: master 1, slave answers on the 4th BUSY cycle
        next_cycle();
        set_master(1, 32'h10, 32'h0, 4'h0);
        m_valid = 3'b010;
        settle();
        check("rd_not_yet_valid", 64'(s_valid), 64'd0);
        sv_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            if (c == 4) begin
                s_ready = 1'b1;
                s_rdata = 32'hCAFEF00D;
                expect_done(1, 32'hCAFEF00D, 1'b0);
            end
            settle();
            if (s_valid) sv_cnt++;
            if (c == 1) begin
                check("rd_grant",  64'(grant),   64'b010);
                check("rd_s_addr", 64'(s_addr),  64'h10);
                check("rd_s_wstrb", 64'(s_wstrb), 64'd0);
            end
        end
        next_cycle();
        s_ready = 1'b0;
        m_valid = '0;
        settle();
        if (s_valid) sv_cnt++;
        check("rd_s_valid_cycles", 64'(sv_cnt), 64'd4);
        check("rd_grant_released", 64'(grant), 64'd0);

        // Contention: fresh reset so rotation starts at master 0
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_master(i, 32'h100 + i, 32'h0, 4'h0);
        m_valid = 3'b111;
        for (int t = 0; t < 6; t++) begin
            next_cycle();
            s_ready = 1'b1;
            s_rdata = 32'hD0 + t;
            expect_done(t % N, 32'hD0 + t, 1'b0);
            settle();
            check("rr_grant",  64'(grant),  64'(1) << (t % N));
            check("rr_s_addr", 64'(s_addr), 64'(32'h100 + t % N));
            next_cycle();
            s_ready = 1'b0;
        end
        m_valid = '0;

        // Write latch: fields corrupted while BUSY must not reach the slave
        next_cycle();
        set_master(0, 32'h20, 32'h12345678, 4'hF);
        m_valid = 3'b001;
        next_cycle();
        set_master(0, 32'h99, 32'hDEADBEEF, 4'h0);
        settle();
        check("wr_s_addr",  64'(s_addr),  64'h20);
        check("wr_s_wdata", 64'(s_wdata), 64'h12345678);
        check("wr_s_wstrb", 64'(s_wstrb), 64'hF);
        next_cycle();
        settle();
        check("wr_s_wdata_held", 64'(s_wdata), 64'h12345678);
        next_cycle();
        s_ready = 1'b1;
        s_rdata = 32'h0;
        expect_done(0, 32'h0, 1'b0);
        settle();
        next_cycle();
        s_ready = 1'b0;
        m_valid = '0;

        // Timeout: slave silent, watchdog completes on the 8th BUSY cycle
        next_cycle();
        set_master(0, 32'h30, 32'h0, 4'h0);
        m_valid = 3'b001;
        s_rdata = 32'h55555555;
        for (int c = 1; c <= TO; c++) begin
            next_cycle();
            if (c == TO) expect_done(0, 32'h0, 1'b1);
            settle();
            check("to_s_valid", 64'(s_valid), 64'd1);
        end
        next_cycle();
        m_valid = '0;
        s_ready = 1'b1;
        settle();
        check("late_ready_m_ready", 64'(m_ready), 64'd0);
        check("late_ready_s_valid", 64'(s_valid), 64'd0);
        check("late_ready_grant",   64'(grant),   64'd0);
        next_cycle();
        s_ready = 1'b0;

        // Tie: slave ready in the same cycle the watchdog would fire
        next_cycle();
        set_master(1, 32'h40, 32'h0, 4'h0);
        m_valid = 3'b010;
        for (int c = 1; c <= TO; c++) begin
            next_cycle();
            if (c == TO) begin
                s_ready = 1'b1;
                s_rdata = 32'hA5A5A5A5;
                expect_done(1, 32'hA5A5A5A5, 1'b0);
            end
            settle();
        end
        next_cycle();
        s_ready = 1'b0;
        m_valid = '0;

        // Reset mid-BUSY, then rotation restarts from master 0
        next_cycle();
        set_master(1, 32'h50, 32'h0, 4'h0);
        m_valid = 3'b010;
        next_cycle();
        settle();
        check("mid_grant", 64'(grant), 64'b010);
        next_cycle();
        rst_n   = 1'b0;
        m_valid = '0;
        settle();
        next_cycle();
        rst_n = 1'b1;
        settle();
        check_idle_outputs("mid_reset");
        set_master(0, 32'h60, 32'h0, 4'h0);
        set_master(2, 32'h70, 32'h0, 4'h0);
        m_valid = 3'b101;
        next_cycle();
        s_ready = 1'b1;
        s_rdata = 32'h11111111;
        expect_done(0, 32'h11111111, 1'b0);
        settle();
        check("post_rst_grant", 64'(grant), 64'b001);
        next_cycle();
        s_ready = 1'b0;
        m_valid = 3'b100;
        next_cycle();
        s_ready = 1'b1;
        s_rdata = 32'h22222222;
        expect_done(2, 32'h22222222, 1'b0);
        settle();
        check("m2_grant",  64'(grant),  64'b100);
        check("m2_s_addr", 64'(s_addr), 64'h70);
        next_cycle();
        s_ready = 1'b0;
        m_valid = '0;
        next_cycle();
        settle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
